// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } imem_state_e;

    function automatic logic addr_ok(input logic [31:0] a,
                                     input int unsigned depth);
        return (a[1:0] == 2'b00) && ({2'b00, a[31:2]} < depth);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder over a loadable instruction memory.
// Define IMEM_WAIT_STATE_EN to insert WAIT_CYCLES wait states per fetch.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] instruction_address,
    output logic        req_ready,
    input  logic        flush,
    output logic [31:0] instruction_read_data,
    output logic        instruction_valid,
    output logic        instruction_fault,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    imem_state_e r_state;
    logic [31:0] r_cap_data;
    logic        r_cap_fault;
    logic [31:0] r_last_data;

    logic        w_accept;
    logic        w_fetch_ok;
    logic        w_load_ok;
    logic        w_resp_fire;
    logic [31:0] w_rdata;

`ifdef IMEM_WAIT_STATE_EN
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] r_wait_cnt;
`else
    logic w_unused_wait;
    assign w_unused_wait = (WAIT_CYCLES != 0);
`endif

    imem_array #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (w_load_ok),
        .waddr (load_addr[AW+1:2]),
        .wdata (load_data),
        .raddr (instruction_address[AW+1:2]),
        .rdata (w_rdata)
    );

    assign req_ready   = !rst && (r_state == IDLE) && !flush && !load_en;
    assign w_accept    = req_valid && req_ready;
    assign w_fetch_ok  = addr_ok(instruction_address, DEPTH_WORDS);
    assign w_load_ok   = load_en && addr_ok(load_addr, DEPTH_WORDS);
    assign w_resp_fire = (r_state == RESP) && !flush;

    // A flushed response never shows its data; the last delivered word is held.
    assign instruction_valid     = w_resp_fire;
    assign instruction_fault     = w_resp_fire && r_cap_fault;
    assign instruction_read_data = w_resp_fire ? r_cap_data : r_last_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cap_data  <= NOP;
            r_cap_fault <= 1'b0;
            r_last_data <= NOP;
`ifdef IMEM_WAIT_STATE_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cap_data  <= w_fetch_ok ? w_rdata : NOP;
                        r_cap_fault <= !w_fetch_ok;
`ifdef IMEM_WAIT_STATE_EN
                        r_wait_cnt  <= '0;
                        r_state     <= (WAIT_CYCLES > 0) ? WAIT : RESP;
`else
                        r_state     <= RESP;
`endif
                    end
                end
                WAIT: begin
`ifdef IMEM_WAIT_STATE_EN
                    if (flush) begin
                        r_wait_cnt <= '0;
                        r_state    <= IDLE;
                    end else if (r_wait_cnt == CW'(WAIT_CYCLES - 1)) begin
                        r_wait_cnt <= '0;
                        r_state    <= RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`else
                    r_state <= IDLE;
`endif
                end
                RESP: begin
                    if (!flush) begin
                        r_last_data <= r_cap_data;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
